// File: rtl/piso_serializer_if.sv
// Handshake and data bundle between a parallel-word producer and the PISO serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             shr;
  logic             shr_out;
  logic             ready;
  logic             busy;
  logic             done;

  modport master (
    output load, din, shr,
    input  shr_out, ready, busy, done
  );

  modport slave (
    input  load, din, shr,
    output shr_out, ready, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: captures a WIDTH-bit word and emits one bit per high shr edge.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             take_load;
  logic             take_bit;
  logic             out_bit;

  // Next-state and datapath strobes
  always_comb begin
    state_d   = state_q;
    take_load = 1'b0;
    take_bit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          take_load = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shr) begin
          take_bit = 1'b1;
          if (cnt == CW'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (take_load) begin
        shreg <= bus.din;
        cnt   <= CW'(WIDTH);
      end else if (take_bit) begin
        shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        // Saturate at zero; the FSM leaves SHIFT before this can matter.
        if (cnt != '0) cnt <= cnt - CW'(1);
      end
    end
  end

  assign out_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  // Outputs decode straight from registered state, so they are glitch-free per cycle
  always_comb begin
    bus.ready   = (state_q == IDLE);
    bus.busy    = (state_q == SHIFT);
    bus.done    = (state_q == DONE);
    bus.shr_out = (state_q == SHIFT) ? out_bit : 1'b0;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: two serializers (LSB-first and MSB-first) driven in lockstep plus a 4-bit SIPO on the LSB-first stream.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(4)) if0 ();
  piso_serializer_if #(.WIDTH(4)) if1 ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic       load, shr;
  logic [3:0] din;
  assign if0.load = load;
  assign if0.din  = din;
  assign if0.shr  = shr;
  assign if1.load = load;
  assign if1.din  = din;
  assign if1.shr  = shr;

  // Receiving SIPO block: shifts shr_in in at the top on every high shr edge
  logic [3:0] sipo;
  always @(posedge clk) begin
    if (rst) sipo <= 4'b0000;
    else if (shr) sipo <= {if0.shr_out, sipo[3:1]};
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   q0[$];
  bit   q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever a serializer hands out a bit, compare it with the scoreboard
  always @(posedge clk) begin
    if (!rst) begin
      if (if0.busy && if0.shr) begin
        if (q0.size() == 0) chk("lsb_stream_extra_bit", 1, 0);
        else chk("lsb_stream_bit", {31'b0, if0.shr_out}, {31'b0, q0.pop_front()});
      end
      if (if1.busy && if1.shr) begin
        if (q1.size() == 0) chk("msb_stream_extra_bit", 1, 0);
        else chk("msb_stream_bit", {31'b0, if1.shr_out}, {31'b0, q1.pop_front()});
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_ready0"}, {31'b0, if0.ready}, 1);
    chk({tag, "_busy0"},  {31'b0, if0.busy}, 0);
    chk({tag, "_done0"},  {31'b0, if0.done}, 0);
    chk({tag, "_out0"},   {31'b0, if0.shr_out}, 0);
    chk({tag, "_ready1"}, {31'b0, if1.ready}, 1);
    chk({tag, "_out1"},   {31'b0, if1.shr_out}, 0);
  endtask

  // mode: 0 = shr always high, N>0 = shr high every Nth cycle, -1 = random shr.
  // abort_at < 4 asserts reset after that many consumed bits.
  task automatic run_word(input logic [3:0] w, input int mode, input bit inject,
                          input int abort_at);
    int c = 0;
    int cyc = 0;
    @(negedge clk);
    chk("pre_load_ready", {31'b0, if0.ready}, 1);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(w[i]);
      q1.push_back(w[3-i]);
    end
    load = 1'b1;
    din  = w;
    shr  = 1'($urandom_range(0, 1));
    @(posedge clk);
    while (c < 4) begin
      @(negedge clk);
      load = 1'b0;
      if (c == abort_at) begin
        rst  = 1'b1;
        load = 1'b1;
        shr  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        shr  = 1'b0;
        q0.delete();
        q1.delete();
        chk_idle("after_abort");
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("no_done_after_abort", {31'b0, if0.done}, 0);
        end
        return;
      end
      chk("busy_shift", {31'b0, if0.busy}, 1);
      chk("ready_shift", {31'b0, if0.ready}, 0);
      chk("hold_lsb", {31'b0, if0.shr_out}, {31'b0, w[c]});
      chk("hold_msb", {31'b0, if1.shr_out}, {31'b0, w[3-c]});
      if (mode == 0)      shr = 1'b1;
      else if (mode > 0)  shr = ((cyc % mode) == (mode - 1));
      else                shr = 1'($urandom_range(0, 1));
      if (inject) begin
        load = 1'b1;
        din  = 4'hF;
      end
      cyc++;
      @(posedge clk);
      if (shr) c++;
      if (cyc > 200) begin
        chk("shift_timeout", 1, 0);
        return;
      end
    end
    @(negedge clk);
    chk("done_pulse", {31'b0, if0.done}, 1);
    chk("done_busy", {31'b0, if0.busy}, 0);
    chk("done_ready", {31'b0, if0.ready}, 0);
    chk("done_out", {31'b0, if0.shr_out}, 0);
    chk("done_pulse_msb", {31'b0, if1.done}, 1);
    chk("sipo_word", {28'b0, sipo}, {28'b0, w});
    load = inject;
    din  = 4'hF;
    shr  = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    shr  = 1'b0;
    chk_idle("post_done");
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    shr  = 1'b0;
    din  = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("idle");

    run_word(4'b1011, 0, 1'b0, 4);
    run_word(4'b0110, 3, 1'b0, 4);
    run_word(4'b0001, 0, 1'b1, 4);
    run_word(4'b1010, 0, 1'b0, 2);
    run_word(4'b0011, 0, 1'b0, 4);
    run_word(4'b1101, 0, 1'b0, 4);

    for (int n = 0; n < 25; n++) begin
      run_word(4'($urandom_range(0, 15)), -1, 1'($urandom_range(0, 1)), 4);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        shr = 1'($urandom_range(0, 1));
      end
      shr = 1'b0;
    end

    @(negedge clk);
    chk("lsb_queue_drained", q0.size(), 0);
    chk("msb_queue_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: parallel word width in bits, legal range 2 to 32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 0: 0 = shift out bit 0 first, 1 = shift out bit WIDTH-1 first.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port load, input, 1 bit: parallel-load request, sampled at the clk edge.
REQ-006 The block SHALL have port din, input, WIDTH bits: parallel word, captured when a load is accepted.
REQ-007 The block SHALL have port shr, input, 1 bit: shift strobe that consumes one serial bit per high clk edge.
REQ-008 The block SHALL have port shr_out, output, 1 bit: serial data, registered-source, intended to drive the shr_in port of the 4-bit SIPO shift block.
REQ-009 The block SHALL have port ready, output, 1 bit: high when the block is idle and will accept a load.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a word is being serialized.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last bit is consumed.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, encoded in registers.
REQ-013 In IDLE, ready SHALL be 1, busy SHALL be 0, done SHALL be 0 and shr_out SHALL be 0.
REQ-014 In IDLE with load=1, the next edge SHALL capture din into the shift register, set the bit counter to WIDTH and enter SHIFT.
REQ-015 In SHIFT, busy SHALL be 1, ready SHALL be 0, and shr_out SHALL equal shreg[0] (MSB_FIRST=0) or shreg[WIDTH-1] (MSB_FIRST=1).
REQ-016 The first serial bit SHALL be valid on shr_out in the cycle after load is accepted (latency 1).
REQ-017 In SHIFT with shr=1, the next edge SHALL shift shreg by one position toward the output end, fill with 0 and decrement the counter.
REQ-018 In SHIFT with shr=0, shreg, the counter and shr_out SHALL hold, with no timeout.
REQ-019 The edge that consumes the final bit (counter=1, shr=1) SHALL move the FSM to DONE; exactly WIDTH high-shr edges SHALL be consumed per word.
REQ-020 In DONE, done SHALL be 1, busy SHALL be 0, ready SHALL be 0 and shr_out SHALL be 0; the next edge SHALL return unconditionally to IDLE.
REQ-021 load SHALL be ignored in SHIFT and DONE; din changes outside the accepting edge SHALL have no effect.
REQ-022 shr SHALL be ignored in IDLE and DONE.
REQ-023 When load=1 and shr=1 on the same edge in IDLE, the load SHALL be taken and no bit SHALL be consumed on that edge.
REQ-024 The counter width SHALL be clog2(WIDTH+1) bits; the counter SHALL never wrap below 0.
REQ-025 Consumer contract: the receiver samples shr_out on the same clk edge where shr=1, so bit n is taken on the n-th high-shr edge.

Reset
REQ-026 rst=1 at a clk edge SHALL force IDLE with shreg=0 and counter=0, giving outputs shr_out=0, ready=1, busy=0 and done=0 from the next cycle.
REQ-027 rst SHALL override load and shr on the same edge, and an in-progress word SHALL be discarded with no done pulse.
REQ-028 After reset deasserts, the first load SHALL behave exactly as after power-up.

Verification
REQ-029 The bench SHALL cover, with WIDTH=4 and MSB_FIRST=0: load din=4'b1011 then shr high 4 cycles -> shr_out 1,1,0,1, done pulses 1 cycle, then ready=1.
REQ-030 The bench SHALL cover, with MSB_FIRST=1: load 4'b1011 -> shr_out 1,0,1,1.
REQ-031 The bench SHALL cover: din=4'b0110 with shr toggling every 3 cycles -> each bit held until consumed, done only after the 4th high-shr edge.
REQ-032 The bench SHALL cover: load pulse with din=4'b1111 during SHIFT of 4'b0001 -> ignored, serial stream stays 1,0,0,0.
REQ-033 The bench SHALL cover: rst=1 after 2 bits of 4'b1010 -> next cycle ready=1, shr_out=0, no done pulse; a new load of 4'b0011 then serializes fully.
REQ-034 The bench SHALL cover: loopback of shr_out to the 4-bit SIPO shift block's shr_in with shared clk and shr, load 4'b1101 -> SIPO out=4'b1101 in the DONE cycle.
